// File: rtl/steak_drawer.sv
// -----------------------------------------------------------------------------
// steak_drawer
//
// Repaints a fixed rectangular steak sprite through the VGA adapter's
// pixel-plot interface, one pixel per clock.
//
// The sprite has two regions:
//   - a rim FAT_W pixels thick, painted with colour_fat;
//   - an interior painted with colour_muscle.
//
// A repaint starts once after reset. After that, one starts whenever either
// input colour differs from the pair that was last painted.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   colour_muscle  interior colour (9 bit)
//   colour_fat     rim colour (9 bit)
//   x, y           plot coordinates (8 / 7 bit)
//   colour         plot colour (9 bit)
//   plot           write strobe, high for every sprite pixel
//   busy           high from LOAD through DONE inclusive
//   done           one-cycle pulse after the last pixel
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module steak_drawer #(
   parameter int X_ORIGIN = 72,
   parameter int Y_ORIGIN = 52,
   parameter int WIDTH    = 16,
   parameter int HEIGHT   = 16,
   parameter int FAT_W    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] colour_muscle,
   input  logic [8:0] colour_fat,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [8:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   // Six-bit counters cover sprite sizes up to 32 with headroom.
   localparam logic [5:0] COL_LAST   = 6'(WIDTH - 1);
   localparam logic [5:0] ROW_LAST   = 6'(HEIGHT - 1);
   localparam logic [5:0] FAT_LO     = 6'(FAT_W);
   localparam logic [5:0] COL_FAT_HI = 6'(WIDTH - FAT_W);
   localparam logic [5:0] ROW_FAT_HI = 6'(HEIGHT - FAT_W);
   localparam logic [7:0] X_BASE     = 8'(X_ORIGIN);
   localparam logic [6:0] Y_BASE     = 7'(Y_ORIGIN);

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

   state_t     state, state_next;
   logic [8:0] snap_muscle, snap_muscle_next;
   logic [8:0] snap_fat, snap_fat_next;
   logic       pending, pending_next;
   logic [5:0] col, col_next, row, row_next;
   logic [5:0] col_step, row_step;
   logic [7:0] x_next;
   logic [6:0] y_next;
   logic [8:0] colour_next;
   logic       plot_next, busy_next, done_next;
   logic       changed;

   function automatic logic [8:0] pixel_colour(input logic [5:0] c, input logic [5:0] r,
                                               input logic [8:0] m, input logic [8:0] f);
      if (c < FAT_LO || c >= COL_FAT_HI || r < FAT_LO || r >= ROW_FAT_HI)
         return f;
      else
         return m;
   endfunction

   always_comb begin
      state_next       = state;
      snap_muscle_next = snap_muscle;
      snap_fat_next    = snap_fat;
      pending_next     = pending;
      col_next         = col;
      row_next         = row;
      x_next           = x;
      y_next           = y;
      colour_next      = colour;
      plot_next        = 1'b0;
      busy_next        = busy;
      done_next        = 1'b0;

      // Raster successor of the pixel currently on the outputs.
      col_step = (col == COL_LAST) ? 6'd0 : col + 6'd1;
      row_step = (col == COL_LAST) ? row + 6'd1 : row;
      changed  = (colour_muscle != snap_muscle) || (colour_fat != snap_fat);

      case (state)
         IDLE: begin
            if (pending || changed) begin
               state_next = LOAD;
               busy_next  = 1'b1;
            end
         end
         LOAD: begin
            // The first pixel is registered on the same edge that captures
            // the snapshot. Its colour therefore comes from the inputs, which
            // are the values being captured.
            snap_muscle_next = colour_muscle;
            snap_fat_next    = colour_fat;
            pending_next     = 1'b0;
            col_next         = 6'd0;
            row_next         = 6'd0;
            x_next           = X_BASE;
            y_next           = Y_BASE;
            colour_next      = pixel_colour(6'd0, 6'd0, colour_muscle, colour_fat);
            plot_next        = 1'b1;
            state_next       = DRAW;
         end
         DRAW: begin
            if (col == COL_LAST && row == ROW_LAST) begin
               done_next  = 1'b1;
               state_next = DONE;
            end else begin
               col_next    = col_step;
               row_next    = row_step;
               x_next      = X_BASE + {2'b00, col_step};
               y_next      = Y_BASE + {1'b0, row_step};
               colour_next = pixel_colour(col_step, row_step, snap_muscle, snap_fat);
               plot_next   = 1'b1;
            end
         end
         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         snap_muscle <= 9'd0;
         snap_fat    <= 9'd0;
         pending     <= 1'b1;
         col         <= 6'd0;
         row         <= 6'd0;
         x           <= 8'd0;
         y           <= 7'd0;
         colour      <= 9'd0;
         plot        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_next;
         snap_muscle <= snap_muscle_next;
         snap_fat    <= snap_fat_next;
         pending     <= pending_next;
         col         <= col_next;
         row         <= row_next;
         x           <= x_next;
         y           <= y_next;
         colour      <= colour_next;
         plot        <= plot_next;
         busy        <= busy_next;
         done        <= done_next;
      end
   end

endmodule

// File: tb/tb_steak_drawer.sv
// -----------------------------------------------------------------------------
// tb_steak_drawer
//
// Self-checking bench for steak_drawer with default parameters.
//
// Expected pixels are queued whenever a repaint is provoked. A negedge
// monitor pops one entry and compares it against every plotted pixel. Table
// records drive the colour pairs and the probe pixels. Hand-written sequences
// cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_steak_drawer;

   localparam int XO = 72;
   localparam int YO = 52;
   localparam int W  = 16;
   localparam int H  = 16;
   localparam int FW = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] colour_muscle = 9'd0;
   logic [8:0] colour_fat = 9'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [8:0] colour;
   logic       plot, busy, done;

   steak_drawer dut (
      .clk(clk), .reset(reset), .colour_muscle(colour_muscle), .colour_fat(colour_fat),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] px;
      logic [6:0] py;
      logic [8:0] pc;
   } pix_t;

   typedef struct {
      logic [8:0] m;
      logic [8:0] f;
      int         fat_cells;
   } vec_t;

   typedef struct {
      int c;
      int r;
      bit fat;
   } probe_t;

   pix_t       exp_q[$];
   logic [8:0] frame [0:H-1][0:W-1];
   int         errors = 0;
   int         checks = 0;
   int         plot_count = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Pixel stream expected from one repaint with the given pair.
   task automatic push_frame(input logic [8:0] m, input logic [8:0] f);
      pix_t p;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            p.px = 8'(XO + c);
            p.py = 7'(YO + r);
            p.pc = (c < FW || c >= W - FW || r < FW || r >= H - FW) ? f : m;
            exp_q.push_back(p);
         end
      end
   endtask

   // Stops in the negedge half of the cycle that shows pixel (c, r).
   task automatic wait_pixel(input string name, input int c, input int r);
      bit seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (plot && x == 8'(XO + c) && y == 7'(YO + r)) seen = 1'b1;
      end
      check({name, "_pixel_reached"}, int'(seen), 1);
   endtask

   task automatic wait_done(input string name, input int left);
      bit seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({name, "_done_seen"}, int'(seen), 1);
      check({name, "_queue_left"}, exp_q.size(), left);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      pix_t e;
      int   fx, fy;
      if (!reset && plot) begin
         plot_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_plot: got (%0d,%0d) colour %h, expected no plot", x, y, colour);
         end else begin
            e = exp_q.pop_front();
            if (x !== e.px || y !== e.py || colour !== e.pc) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d) colour %h, expected (%0d,%0d) colour %h",
                        x, y, colour, e.px, e.py, e.pc);
            end
         end
         fx = int'(x) - XO;
         fy = int'(y) - YO;
         if (fx >= 0 && fx < W && fy >= 0 && fy < H) frame[fy][fx] = colour;
      end
   end

   initial begin
      vec_t   vecs[3];
      probe_t probes[7];
      int     p0, cnt, bad;

      vecs[0] = '{9'h1C0, 9'h1FF, 112};
      vecs[1] = '{9'h0AA, 9'h155, 112};
      vecs[2] = '{9'h000, 9'h1FF, 112};
      probes[0] = '{0, 0, 1'b1};
      probes[1] = '{1, 5, 1'b1};
      probes[2] = '{15, 15, 1'b1};
      probes[3] = '{5, 14, 1'b1};
      probes[4] = '{2, 2, 1'b0};
      probes[5] = '{13, 13, 1'b0};
      probes[6] = '{7, 8, 1'b0};

      // Reset state
      #12;
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_colour", int'(colour), 0);
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);

      // Post-reset repaint with 0/0
      push_frame(9'd0, 9'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_load_busy", int'(busy), 1);
      check("post_rst_load_plot", int'(plot), 0);
      @(posedge clk); #1;
      check("post_rst_first_plot", int'(plot), 1);
      check("post_rst_first_x", int'(x), XO);
      check("post_rst_first_y", int'(y), YO);
      wait_done("post_rst", 0);
      check("post_rst_plot_count", plot_count, W * H);
      @(posedge clk); #1;
      check("post_rst_done_pulse", int'(done), 0);
      check("post_rst_busy_after", int'(busy), 0);

      // Table-driven colour pairs with probe pixels
      for (int v = 0; v < 3; v++) begin
         p0 = plot_count;
         push_frame(vecs[v].m, vecs[v].f);
         colour_muscle = vecs[v].m;
         colour_fat = vecs[v].f;
         wait_done($sformatf("vec%0d", v), 0);
         check($sformatf("vec%0d_plots", v), plot_count - p0, W * H);
         cnt = 0;
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               if (frame[r][c] == vecs[v].f) cnt++;
         check($sformatf("vec%0d_fat_cells", v), cnt, vecs[v].fat_cells);
         for (int k = 0; k < 7; k++)
            check($sformatf("vec%0d_probe_%0d_%0d", v, probes[k].c, probes[k].r),
                  int'(frame[probes[k].r][probes[k].c]),
                  int'(probes[k].fat ? vecs[v].f : vecs[v].m));
      end

      // Stable inputs: nothing happens
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (plot || busy || done) bad++;
      end
      check("stable_activity", bad, 0);

      // Mid-repaint change at pixel 100 (col 4, row 6)
      p0 = plot_count;
      push_frame(9'h0F0, 9'h10F);
      colour_muscle = 9'h0F0;
      colour_fat = 9'h10F;
      wait_pixel("mid", 4, 6);
      push_frame(9'h123, 9'h045);
      colour_muscle = 9'h123;
      colour_fat = 9'h045;
      wait_done("mid_first", W * H);
      @(posedge clk); #1;
      check("mid_idle_busy", int'(busy), 0);
      @(posedge clk); #1;
      check("mid_load_busy", int'(busy), 1);
      check("mid_load_plot", int'(plot), 0);
      @(posedge clk); #1;
      check("mid_second_first_plot", int'(plot), 1);
      wait_done("mid_second", 0);
      check("mid_plots", plot_count - p0, 2 * W * H);

      // Change and revert during DRAW: exactly one repaint
      p0 = plot_count;
      push_frame(9'h1AB, 9'h0CD);
      colour_muscle = 9'h1AB;
      colour_fat = 9'h0CD;
      wait_pixel("revert_a", 4, 1);
      colour_muscle = 9'h000;
      colour_fat = 9'h000;
      wait_pixel("revert_b", 12, 3);
      colour_muscle = 9'h1AB;
      colour_fat = 9'h0CD;
      wait_done("revert", 0);
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (busy) bad++;
      end
      check("revert_no_second", bad, 0);
      check("revert_plots", plot_count - p0, W * H);

      // Asynchronous reset at pixel 50 (col 2, row 3)
      push_frame(9'h055, 9'h1AA);
      colour_muscle = 9'h055;
      colour_fat = 9'h1AA;
      wait_pixel("rst50", 2, 3);
      #2 reset = 1'b1;
      #1;
      check("rst50_plot_async", int'(plot), 0);
      check("rst50_busy_async", int'(busy), 0);
      check("rst50_x_async", int'(x), 0);
      exp_q.delete();
      push_frame(9'h055, 9'h1AA);
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b0;
      p0 = plot_count;
      wait_done("rst50", 0);
      check("rst50_plots", plot_count - p0, W * H);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/steak_drawer.md
# steak_drawer

Downstream render stage for the steak doneness controller. It takes the two 9-bit colours the controller produces (`colour_muscle`, `colour_fat`) and repaints a fixed rectangular steak sprite into the VGA adapter's pixel-plot interface, one pixel per clock. A repaint starts whenever either colour differs from the last painted pair, and also once after reset. Output ports match the VGA adapter's x/y/colour/plot inputs directly.

## Interface
- `X_ORIGIN`, default 72: left column of sprite on the 160x120 screen.
- `Y_ORIGIN`, default 52: top row of sprite.
- `WIDTH`, default 16: sprite width in pixels, range 2..32.
- `HEIGHT`, default 16: sprite height in pixels, range 2..32.
- `FAT_W`, default 2: thickness of the fat rim in pixels; requires 2*FAT_W <= min(WIDTH, HEIGHT).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  input  1  system clock (50 MHz board clock).
- `reset`  input  1  asynchronous reset, active-high.
- `colour_muscle`  input  9  interior colour from the doneness controller.
- `colour_fat`  input  9  rim colour from the doneness controller.
- `x`  output  8  VGA plot column.
- `y`  output  7  VGA plot row.
- `colour`  output  9  VGA plot colour.
- `plot`  output  1  VGA write enable; 1 = write (x, y, colour) this cycle.
- `busy`  output  1  high from LOAD through DONE inclusive.
- `done`  output  1  one-cycle pulse when a repaint completes.

## Operation
- State machine states: IDLE, LOAD, DRAW, DONE.
- Internal registers:
  - `snap_muscle`, `snap_fat`: colours being or last painted; reset to 0.
  - `pending`: set to 1 by reset.
  - `col` and `row` counters.
- **IDLE:** go to LOAD if `pending`, or if `colour_muscle != snap_muscle`, or if `colour_fat != snap_fat`. Otherwise stay in IDLE.
- **LOAD (1 cycle):** capture both inputs into the snap registers, clear `pending`, set col = row = 0, go to DRAW.
- **DRAW:** one pixel per cycle, with `plot` = 1.
  - x = X_ORIGIN + col and y = Y_ORIGIN + row, each truncated to port width. There is no clipping; parameters must keep the sprite on screen.
  - A pixel is fat if col < FAT_W, col >= WIDTH-FAT_W, row < FAT_W, or row >= HEIGHT-FAT_W. Fat pixels take `snap_fat`; all others take `snap_muscle`.
  - Scan is raster order: col increments; at WIDTH-1 it wraps to 0 and row increments.
  - After pixel (WIDTH-1, HEIGHT-1) is issued, go to DONE.
- **DONE (1 cycle):** `done` = 1, `plot` = 0, then go to IDLE.
- Input changes during LOAD, DRAW or DONE are ignored for the current repaint. Because IDLE re-compares, the latest values are repainted afterwards. Intermediate values that have already reverted are never drawn.
- A colour pair of 0/0 (non-existent steak) paints black over the whole sprite. This erases the sprite; it is not a special case.
- Reset mid-repaint aborts immediately. All outputs take reset values, and a full repaint follows from `pending`.

## Timing
- All outputs are registered.
- Reset values: x = 0, y = 0, colour = 0, plot = 0, busy = 0, done = 0, state = IDLE, pending = 1.
- Cycle sequence, with the colour change (or pending) sampled in IDLE at edge E:
  - LOAD during cycle E+1.
  - First plotted pixel, (X_ORIGIN, Y_ORIGIN), valid in cycle E+2.
  - Last pixel in cycle E+1+WIDTH*HEIGHT.
  - `done` pulse in the following cycle.
  - IDLE in the cycle after that.
- Repaint length is WIDTH*HEIGHT+2 cycles with `busy` high; with defaults, 258 cycles.
- `plot` is continuous during DRAW: exactly WIDTH*HEIGHT consecutive high cycles and no gaps.
- Earliest start of the next repaint is the cycle after returning to IDLE. There is no back-to-back overlap.

## Test plan
- **Post-reset repaint:** release reset with inputs 0/0. Expect 256 plots, all with colour 0; the first at (72,52) two cycles after release, the last at (87,67); one `done` pulse; then idle.
- **Rim/interior split:** after idle, set muscle = 9'h1C0 and fat = 9'h1FF.
  - Pixels (0,0), (1,5), (15,15) and (5,14) show 9'h1FF.
  - Pixels (2,2), (13,13) and (7,8) show 9'h1C0.
  - Exactly 256 - 144 = 112 fat pixels.
- **Stable inputs:** hold the same colours for 1000 cycles after `done`. Expect `plot`, `busy` and `done` to stay 0.
- **Mid-repaint change:** change the colours again at DRAW pixel 100.
  - The current repaint finishes entirely with the old pair.
  - A second repaint with the new pair starts two cycles after the `done` pulse.
- **Change and revert during DRAW:** change the colours, then restore them before the repaint ends. Expect exactly one repaint and no second one.
- **Reset at pixel 50:** assert reset asynchronously during DRAW pixel 50.
  - `plot` goes low immediately, without waiting for a clock edge.
  - After release, a complete 256-pixel repaint runs with the current inputs.
